opc_int_ctrl: RTL and testbench
===============================

Name: opc_int_ctrl

Overview:
- Memory-mapped interrupt controller that drives the CPU's active-low `int_b` input.
- Collects up to 16 peripheral interrupt sources, each configurable as edge- or level-triggered.
- Latches each source into a pending register, masks it, and asserts `int_b` low while any unmasked source is pending.
- Sits on the CPU's 16-bit data bus next to memory; the address decoder supplies a chip select and the low address bits.

Parameters:
- NSRC, 8, number of interrupt sources (legal range 1..16); register bits [15:NSRC] read 0 and ignore writes.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_b  input  1  asynchronous active-low reset.
- cs  input  1  chip select from the address decoder; high = this block is addressed.
- reg_addr  input  2  register select (CPU address[1:0]).
- rnw  input  1  1 = read, 0 = write (CPU rnw).
- wdata  input  16  write data (CPU dout).
- rdata  output  16  read data (muxed onto CPU din by the decoder); combinational.
- irq_src  input  NSRC  interrupt request lines, synchronous to clk, active high.
- int_b  output  1  registered active-low interrupt request to the CPU.

Behaviour:
- Register map:
  - 0 PEND: read pending; write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 VECTOR: read-only; writes are ignored.
- Write strobe: `cs && !rnw`, sampled at posedge clk. Reads have no side effects.
- `rdata`: combinational from `cs`, `reg_addr` and current register state. It is 16'h0000 when `cs` is 0.
- Source sampling: `src_q` holds last cycle's `irq_src`.
  - Edge mode: bit i is set at the posedge where `irq_src[i]` = 1 and `src_q[i]` = 0.
  - Level mode: bit i is set at any posedge where `irq_src[i]` = 1.
- PEND update, per bit at each posedge:
  - next = (PEND & ~clr) | set, where clr = wdata when writing PEND, else 0.
  - A set wins over a simultaneous clear.
  - A level-mode bit therefore cannot be cleared while its source stays high.
- PEND is independent of MASK: a masked source still latches its pending bit.
- int_b:
  - Registered: int_b <= ~|(PEND_next & MASK_next).
  - Latency from the edge-sampling posedge: PEND is visible immediately after the posedge at which the edge is detected, and int_b falls at that same posedge (registered from next-state).
  - Clearing the last active bit, or masking it, raises int_b at the posedge of the write.
- VECTOR:
  - Equals the index of the lowest-numbered set bit of (PEND & MASK), zero-extended.
  - Equals 16'hFFFF when none is set.
- MODE changes take effect at the next posedge. `src_q` keeps updating regardless of MODE, so switching to edge mode while a source is high does not create an edge.
- Reset (asynchronous, while reset_b = 0):
  - PEND = 0, MASK = 0, MODE = all 1s (edge), src_q = 0, int_b = 1.
  - Assertion mid-operation immediately forces int_b high and discards pending events.
  - A source that is already high at reset release is seen as a rising edge on the first posedge.
- int_b is a level output: it stays low until software clears or masks the source. There is no acknowledge handshake.

Test Plan:
- Reset/defaults: assert reset_b low mid-run with PEND = 8'h05 -> int_b = 1 immediately. After release, reads return PEND = 0, MASK = 0, MODE = 8'hFF, VECTOR = 16'hFFFF.
- Edge latch and clear:
  - Write MASK = 8'h08; pulse irq_src[3] for 1 cycle -> PEND = 8'h08, int_b = 0, VECTOR = 3.
  - Write PEND = 8'h08 -> int_b = 1 after that posedge, PEND = 0.
- Masking and priority:
  - Sources 1 and 6 pending with MASK = 0 -> int_b stays 1.
  - Write MASK = 8'h42 -> int_b = 0 and VECTOR = 1.
  - Clear bit 1 -> VECTOR = 6.
- Simultaneous set/clear: a new rising edge on source 2 in the same cycle as a PEND write of 8'h04 -> PEND[2] remains 1 and int_b stays 0.
- Level mode:
  - MODE = 8'hFE, MASK = 8'h01, irq_src[0] held high -> a PEND write of 1 does not clear it and int_b stays 0.
  - Drop irq_src[0], then clear -> PEND[0] = 0 and int_b = 1.
- Bus isolation:
  - A write with cs = 0 changes nothing.
  - A write to VECTOR is ignored.
  - With NSRC = 8, writing MASK = 16'hFFFF reads back 16'h00FF.
  - rdata = 0 whenever cs = 0.

Source files
------------

// File: rtl/opc_int_ctrl.sv
// Memory-mapped interrupt controller: latches up to 16 edge/level sources into PEND,
// gates them with MASK and drives the CPU's active-low int_b.
module opc_int_ctrl #(
    parameter int unsigned NSRC = 8
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            cs,
    input  logic [1:0]      reg_addr,
    input  logic            rnw,
    input  logic [15:0]     wdata,
    output logic [15:0]     rdata,
    input  logic [NSRC-1:0] irq_src,
    output logic            int_b
);

    localparam logic [1:0] AddrPend = 2'd0;
    localparam logic [1:0] AddrMask = 2'd1;
    localparam logic [1:0] AddrMode = 2'd2;
    localparam logic [1:0] AddrVec  = 2'd3;

    logic            wr_en;
    logic [NSRC-1:0] wdata_src;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] set_vec, clr_vec;
    logic [NSRC-1:0] active;
    logic [15:0]     vector;

    assign wdata_src = NSRC'(wdata);

    always_comb begin
        wr_en   = cs && !rnw;
        // Edge-mode bits need a 0->1 transition; level-mode bits fire whenever high.
        set_vec = irq_src & (~mode_q | ~src_q);
        clr_vec = '0;
        mask_d  = mask_q;
        mode_d  = mode_q;
        if (wr_en) begin
            case (reg_addr)
                AddrPend: clr_vec = wdata_src;
                AddrMask: mask_d  = wdata_src;
                AddrMode: mode_d  = wdata_src;
                default:  ;
            endcase
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    always_comb begin
        active = pend_q & mask_q;
        vector = 16'hFFFF;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (active[i]) vector = 16'(i);
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (cs) begin
            case (reg_addr)
                AddrPend: rdata = 16'(pend_q);
                AddrMask: rdata = 16'(mask_q);
                AddrMode: rdata = 16'(mode_q);
                AddrVec:  rdata = vector;
                default:  rdata = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '1;
            src_q  <= '0;
            int_b  <= 1'b1;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            src_q  <= irq_src;
            int_b  <= ~|(pend_d & mask_d);
        end
    end

endmodule

// File: tb/tb_opc_int_ctrl.sv
// Self-checking bench for opc_int_ctrl: directed scenarios then random bus/source traffic,
// compared against a per-source behavioural model.
module tb_opc_int_ctrl;

    localparam int NSRC = 8;

    logic            clk;
    logic            reset_b;
    logic            cs;
    logic [1:0]      reg_addr;
    logic            rnw;
    logic [15:0]     wdata;
    logic [15:0]     rdata;
    logic [NSRC-1:0] irq_src;
    logic            int_b;

    int n_assert;
    int n_fail;

    // Model state: one entry per source.
    bit m_pend [NSRC];
    bit m_mask [NSRC];
    bit m_edge [NSRC];
    bit m_prev [NSRC];
    bit m_intb;

    opc_int_ctrl #(.NSRC(NSRC)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .cs       (cs),
        .reg_addr (reg_addr),
        .rnw      (rnw),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq_src  (irq_src),
        .int_b    (int_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_pend[i] = 0;
            m_mask[i] = 0;
            m_edge[i] = 1;
            m_prev[i] = 0;
        end
        m_intb = 1;
    endtask

    function automatic logic [15:0] pack(input bit v [NSRC]);
        int acc = 0;
        for (int i = 0; i < NSRC; i++) if (v[i]) acc += (1 << i);
        return acc[15:0];
    endfunction

    function automatic logic [15:0] model_vector();
        for (int i = 0; i < NSRC; i++) if (m_pend[i] && m_mask[i]) return i[15:0];
        return 16'hFFFF;
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return pack(m_pend);
            2'd1:    return pack(m_mask);
            2'd2:    return pack(m_edge);
            default: return model_vector();
        endcase
    endfunction

    // Apply the rules of one clock edge given the bus/source values seen at it.
    task automatic model_tick(input logic c, input logic [1:0] a, input logic r,
                              input logic [15:0] w, input logic [NSRC-1:0] s);
        bit wr;
        bit any_active;
        wr = c && !r;
        any_active = 0;
        for (int i = 0; i < NSRC; i++) begin
            bit fire;
            fire = m_edge[i] ? (s[i] && !m_prev[i]) : s[i];
            if (fire) m_pend[i] = 1;
            else if (wr && a == 2'd0 && w[i]) m_pend[i] = 0;
            if (wr && a == 2'd1) m_mask[i] = w[i];
            if (wr && a == 2'd2) m_edge[i] = w[i];
            m_prev[i] = s[i];
            if (m_pend[i] && m_mask[i]) any_active = 1;
        end
        m_intb = !any_active;
    endtask

    task automatic drive(input logic c, input logic [1:0] a, input logic r,
                         input logic [15:0] w, input logic [NSRC-1:0] s);
        cs = c; reg_addr = a; rnw = r; wdata = w; irq_src = s;
        @(posedge clk);
        model_tick(c, a, r, w, s);
        #1;
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a);
        cs = 1'b1; rnw = 1'b1; reg_addr = a;
        #1;
        check(tag, rdata, model_read(a));
        cs = 1'b0;
    endtask

    task automatic check_int(input string tag);
        check(tag, {15'd0, int_b}, {15'd0, m_intb});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_b  = 1'b0;
        cs = 1'b0; reg_addr = 2'd0; rnw = 1'b1; wdata = 16'h0; irq_src = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b1;
        check_int("rst_int_b");
        check_reg("rst_pend", 2'd0);
        check_reg("rst_mask", 2'd1);
        check_reg("rst_mode", 2'd2);
        check_reg("rst_vector", 2'd3);

        // Edge latch and clear
        drive(1, 2'd1, 0, 16'h0008, 8'h00);
        drive(0, 2'd0, 1, 16'h0000, 8'h08);
        check_int("edge_int_low");
        check_reg("edge_pend", 2'd0);
        check_reg("edge_vector", 2'd3);
        drive(0, 2'd0, 1, 16'h0000, 8'h00);
        drive(1, 2'd0, 0, 16'h0008, 8'h00);
        check_int("clear_int_high");
        check_reg("clear_pend", 2'd0);

        // Masking and priority
        drive(1, 2'd1, 0, 16'h0000, 8'h00);
        drive(0, 2'd0, 1, 16'h0000, 8'h42);
        drive(0, 2'd0, 1, 16'h0000, 8'h00);
        check_int("masked_int_high");
        check_reg("masked_pend", 2'd0);
        drive(1, 2'd1, 0, 16'h0042, 8'h00);
        check_int("unmask_int_low");
        check_reg("prio_vector1", 2'd3);
        drive(1, 2'd0, 0, 16'h0002, 8'h00);
        check_reg("prio_vector6", 2'd3);

        // Simultaneous set and clear on source 2
        drive(1, 2'd1, 0, 16'h0044, 8'h00);
        drive(0, 2'd0, 1, 16'h0000, 8'h04);
        drive(0, 2'd0, 1, 16'h0000, 8'h00);
        drive(1, 2'd0, 0, 16'h0004, 8'h04);
        check_reg("setclr_pend", 2'd0);
        check_int("setclr_int_low");
        drive(1, 2'd0, 0, 16'h0044, 8'h00);
        check_int("clearall_int_high");

        // Level mode
        drive(1, 2'd2, 0, 16'h00FE, 8'h00);
        drive(1, 2'd1, 0, 16'h0001, 8'h00);
        drive(0, 2'd0, 1, 16'h0000, 8'h01);
        drive(1, 2'd0, 0, 16'h0001, 8'h01);
        check_reg("level_noclear_pend", 2'd0);
        check_int("level_noclear_int");
        drive(0, 2'd0, 1, 16'h0000, 8'h00);
        drive(1, 2'd0, 0, 16'h0001, 8'h00);
        check_reg("level_clear_pend", 2'd0);
        check_int("level_clear_int");

        // Switching to edge mode while a source is high must not create an edge
        drive(0, 2'd0, 1, 16'h0000, 8'h01);
        drive(1, 2'd0, 0, 16'h0001, 8'h01);
        drive(1, 2'd2, 0, 16'h00FF, 8'h01);
        drive(1, 2'd0, 0, 16'h0001, 8'h01);
        drive(0, 2'd0, 1, 16'h0000, 8'h01);
        check_reg("modeswitch_pend", 2'd0);
        check_int("modeswitch_int");
        drive(0, 2'd0, 1, 16'h0000, 8'h00);

        // Bus isolation
        drive(0, 2'd1, 0, 16'hFFFF, 8'h00);
        check_reg("cs0_write_mask", 2'd1);
        drive(1, 2'd3, 0, 16'h1234, 8'h00);
        check_reg("vec_write_ignored", 2'd3);
        check_reg("vec_write_mask", 2'd1);
        drive(1, 2'd1, 0, 16'hFFFF, 8'h00);
        check_reg("mask_upper_zero", 2'd1);
        cs = 1'b0; reg_addr = 2'd1; #1;
        check("rdata_cs0", rdata, 16'h0000);

        // Mid-run reset with PEND = 0x05
        drive(0, 2'd0, 1, 16'h0000, 8'h05);
        drive(0, 2'd0, 1, 16'h0000, 8'h00);
        check_reg("prereset_pend", 2'd0);
        check_int("prereset_int");
        @(negedge clk);
        reset_b = 1'b0;
        irq_src = 8'h01;
        #1;
        model_reset();
        check("async_reset_int_b", {15'd0, int_b}, 16'h0001);
        @(posedge clk);
        #1 reset_b = 1'b1;
        check_reg("release_pend", 2'd0);
        check_reg("release_mask", 2'd1);
        check_reg("release_mode", 2'd2);
        check_reg("release_vector", 2'd3);
        drive(0, 2'd0, 1, 16'h0000, 8'h01);
        check_reg("release_edge_pend", 2'd0);
        drive(1, 2'd1, 0, 16'h00FF, 8'h00);
        check_int("release_edge_int");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic            c;
            logic [1:0]      a;
            logic [NSRC-1:0] s;
            c = ($urandom_range(0, 2) == 0);
            a = 2'($urandom_range(0, 3));
            s = NSRC'($urandom & $urandom);
            drive(c, a, 1'($urandom_range(0, 1)), 16'($urandom), s);
            check_int("rand_int_b");
            check_reg("rand_read", 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
